// File: rtl/l2_cacheline_adaptor.sv
// Splits single-cycle L2 line requests into s_line/s_burst-beat memory bursts
// and reassembles fetched beats into a full line for the cache.
module l2_cacheline_adaptor #(
  parameter int s_line   = 256,
  parameter int s_burst  = 64,
  parameter int s_offset = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);
  localparam int beats = s_line / s_burst;
  localparam int cw    = (beats > 1) ? $clog2(beats) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state;
  logic [cw-1:0]     cnt;
  logic [s_line-1:0] wbuf;
  logic [31:0]       addr;
  logic              last;

  assign last = (cnt == cw'(beats - 1));

  // Beat count is a power of two, so cnt+1 wraps to 0 on the final beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      wbuf   <= '0;
      addr   <= '0;
      line_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (write_i) begin
            wbuf  <= line_i;
            addr  <= {address_i[31:s_offset], {s_offset{1'b0}}};
            state <= WR;
          end else if (read_i) begin
            addr  <= {address_i[31:s_offset], {s_offset{1'b0}}};
            state <= RD;
          end
        end
        RD: begin
          if (resp_i) begin
            line_o[s_burst*cnt +: s_burst] <= burst_i;
            cnt <= cnt + 1'b1;
            if (last) state <= DONE;
          end
        end
        WR: begin
          if (resp_i) begin
            cnt <= cnt + 1'b1;
            if (last) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; reset clears them immediately.
  assign read_o    = (state == RD);
  assign write_o   = (state == WR);
  assign resp_o    = (state == DONE);
  assign address_o = (state == RD || state == WR) ? addr : 32'h0;
  assign burst_o   = (state == WR) ? wbuf[s_burst*cnt +: s_burst] : '0;
endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Directed table-driven bench for l2_cacheline_adaptor plus reset/stray-ack sequences.
module tb_l2_cacheline_adaptor;
  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  int checks = 0;
  int errors = 0;

  l2_cacheline_adaptor dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             rd;
    logic             wr;
    logic [31:0]      addr;
    logic [255:0]     line;
    logic [3:0][63:0] beat;
    logic [31:0]      gap;
    logic [31:0]      exp_addr;
    logic [255:0]     exp_line;
    logic [3:0][63:0] exp_beat;
  } vec_t;

  vec_t vt [4];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int hi;
    hi = 0;
    @(negedge clk);
    read_i = v.rd; write_i = v.wr; address_i = v.addr; line_i = v.line; resp_i = 1'b0;
    tick();
    // Controller drops the request and scribbles on its inputs mid-burst.
    read_i = 1'b0; write_i = 1'b0; address_i = ~v.addr; line_i = ~v.line;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin
        for (int g = 0; g < int'(v.gap); g++) begin
          resp_i = 1'b0;
          burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
          chk("gap_read_o", read_o, !v.wr);
          chk("gap_write_o", write_o, v.wr);
          chk("gap_addr", address_o, v.exp_addr);
          if (v.wr) chk("gap_burst_o", burst_o, v.exp_beat[b]);
          if (read_o || write_o) hi++;
          tick();
        end
      end
      resp_i = 1'b1;
      burst_i = v.beat[b];
      chk("beat_read_o", read_o, !v.wr);
      chk("beat_write_o", write_o, v.wr);
      chk("beat_addr", address_o, v.exp_addr);
      chk("beat_resp_o", resp_o, 1'b0);
      if (v.wr) chk("beat_burst_o", burst_o, v.exp_beat[b]);
      if (read_o || write_o) hi++;
      tick();
      resp_i = 1'b0;
    end
    chk("done_resp_o", resp_o, 1'b1);
    chk("done_read_o", read_o, 1'b0);
    chk("done_write_o", write_o, 1'b0);
    chk("done_addr", address_o, 32'h0);
    chk("done_line_o", line_o, v.exp_line);
    chk("req_high_cycles", hi, 4 + 3 * v.gap);
    tick();
    chk("idle_resp_o", resp_o, 1'b0);
    chk("idle_req", {read_o, write_o}, 2'b00);
    chk("idle_line_o", line_o, v.exp_line);
  endtask

  initial begin
    vt[0] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_1234,
              line: 256'h0,
              beat: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
              gap: 32'd0, exp_addr: 32'h0000_1220,
              exp_line: 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
              exp_beat: '0};
    vt[1] = '{rd: 1'b0, wr: 1'b1, addr: 32'h8000_003F,
              line: 256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA,
              beat: {4{64'hDEAD_BEEF_DEAD_BEEF}},
              gap: 32'd1, exp_addr: 32'h8000_0020,
              exp_line: 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
              exp_beat: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                         64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}};
    vt[2] = '{rd: 1'b1, wr: 1'b1, addr: 32'h0000_0047,
              line: 256'h0000000000000004_0000000000000003_0000000000000002_0000000000000001,
              beat: {4{64'hFACE_FACE_FACE_FACE}},
              gap: 32'd0, exp_addr: 32'h0000_0040,
              exp_line: 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
              exp_beat: {64'h4, 64'h3, 64'h2, 64'h1}};
    vt[3] = '{rd: 1'b1, wr: 1'b0, addr: 32'hFFFF_FFFF,
              line: 256'h0,
              beat: {64'hA5A5_A5A5_A5A5_A5A5, 64'h0F0F_0F0F_0F0F_0F0F,
                     64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF},
              gap: 32'd2, exp_addr: 32'hFFFF_FFE0,
              exp_line: 256'hA5A5A5A5A5A5A5A5_0F0F0F0F0F0F0F0F_FEDCBA9876543210_0123456789ABCDEF,
              exp_beat: '0};

    rst = 1'b0; read_i = 1'b1; write_i = 1'b0; address_i = 32'h0000_1234;
    line_i = '1; burst_i = 64'h9999_9999_9999_9999; resp_i = 1'b0;

    // Held in reset with a pending read and a toggling ack: nothing moves.
    for (int i = 0; i < 4; i++) begin
      resp_i = ~resp_i;
      tick();
      chk("rst_outs", {read_o, write_o, resp_o, address_o, burst_o}, '0);
      chk("rst_line_o", line_o, 256'h0);
    end

    @(negedge clk);
    rst = 1'b1; resp_i = 1'b0;
    tick();
    chk("post_rst_read_o", read_o, 1'b1);
    chk("post_rst_addr", address_o, 32'h0000_1220);
    read_i = 1'b0;

    resp_i = 1'b1; burst_i = 64'h5555_5555_5555_5555;
    tick();
    burst_i = 64'h6666_6666_6666_6666;
    tick();
    resp_i = 1'b0;
    chk("partial_line_o", line_o[127:0], 128'h6666666666666666_5555555555555555);
    // Asynchronous abort between edges.
    #2 rst = 1'b0;
    #1;
    chk("abort_line_o", line_o, 256'h0);
    chk("abort_outs", {read_o, write_o, resp_o, address_o}, '0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("abort_no_resume", {read_o, write_o, resp_o}, 3'b000);

    for (int i = 0; i < 4; i++) run_vec(vt[i]);

    // Stray acknowledges in IDLE must not touch line_o or start anything.
    @(negedge clk);
    resp_i = 1'b1; burst_i = 64'h7777_7777_7777_7777;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stray_line_o", line_o, vt[3].exp_line);
      chk("stray_outs", {read_o, write_o, resp_o}, 3'b000);
    end
    resp_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/l2_cacheline_adaptor.md
# l2_cacheline_adaptor

Converts the L2 cache's single-cycle 256-bit line requests into 64-bit, four-beat bursts on physical memory, and back again. It sits directly downstream of the L2 cache datapath and controller:
- on the cache side it takes the line address, line write data and read/write strobes;
- on the cache side it returns the fetched line and a one-cycle completion pulse.

It owns the beat counter, the line shift/assembly and the burst handshake, so the L2 cache never sees beat-level timing.

## Interface
Parameters:
- s_line, 256, cache line width in bits
- s_burst, 64, memory beat width in bits. Beat count `s_line/s_burst` must be a power of two, ≥2 (default 4).
- s_offset, 5, line offset bits forced to zero on the memory address

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- line_i  in  s_line  line to write back (from L2 datapath cacheline_in)
- line_o  out  s_line  assembled fetched line (to L2 datapath cacheline_out)
- address_i  in  32  line address from L2 (cacheline_addr_in)
- read_i  in  1  line read request
- write_i  in  1  line write request (cacheline_write)
- resp_o  out  1  one-cycle completion pulse
- burst_i  in  s_burst  read beat from memory
- burst_o  out  s_burst  write beat to memory
- address_o  out  32  burst address to memory
- read_o  out  1  burst read request
- write_o  out  1  burst write request
- resp_i  in  1  memory beat acknowledge; one beat per cycle that it is high

## Operation
- States: IDLE, RD, WR, DONE.
- **IDLE**
  - If write_i=1: latch line_i into wbuf, latch address; go to WR.
  - Else if read_i=1: latch address; go to RD.
  - Write wins when both are high. The read is not queued; the controller must re-present it.
  - Beat counter cleared.
- **Latched address:** `{address_i[31:s_offset], s_offset'b0}`. address_o is driven from the latched value in RD/WR and is 0 in IDLE/DONE.
- **RD**
  - read_o=1.
  - On each cycle with resp_i=1: `line_o[s_burst*cnt +: s_burst] <= burst_i`, cnt++.
  - On the final beat (cnt = beats-1 with resp_i): go to DONE.
- **WR**
  - write_o=1, `burst_o = wbuf[s_burst*cnt +: s_burst]` (combinational from cnt).
  - Each resp_i=1 consumes one beat, cnt++.
  - On the final beat: go to DONE.
- **DONE:** resp_o=1 for exactly one cycle; unconditionally go to IDLE.
- resp_i low between beats is legal. The counter holds, and read_o/write_o and burst_o stay stable.
- resp_i in IDLE or DONE is ignored: no state, counter or line_o change.
- The counter is log2(beats) bits and wraps to 0 on the final beat.
- **line_o**
  - Updated only by RD beats.
  - Holds its value after DONE until the next read's beats overwrite it.
  - Beat 0 occupies bits [63:0].
- **Requests during RD/WR/DONE:** read_i/write_i/address_i/line_i changes are ignored; the latched values govern.
- **Reset (rst=0), any state, including mid-burst:**
  - Asynchronously go to IDLE, cnt=0, wbuf=0, line_o=0, address latch=0.
  - Outputs: resp_o=0, read_o=0, write_o=0, address_o=0, burst_o=0.
  - A burst aborted by reset is not resumed.

## Timing
- Request sampled at edge k (IDLE) → read_o/write_o high from cycle k+1.
- With resp_i high on 4 consecutive cycles starting at cycle k+1+w:
  - final beat captured at edge k+4+w;
  - resp_o high during cycle k+5+w.
  - Minimum request-to-resp_o latency (w=0) is 5 cycles.
- read_o/write_o drop in the same cycle that resp_o rises (DONE drives neither).
- line_o is valid when resp_o is high.
- IDLE is reached the cycle after resp_o. The controller must deassert read_i/write_i by then, or a new transaction starts.
- No combinational path from read_i/write_i to any output. burst_o depends only on registered state.

## Test plan
- **Reset:** hold rst=0 with read_i=1 and resp_i toggling → all outputs 0, no state change. Release → IDLE; read_o rises one cycle after the read_i sample.
- **Read burst:** read_i with address_i=0x0000_1234; resp_i high ×4 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44. Required:
  - address_o=0x0000_1220;
  - resp_o high on cycle 5 after the request;
  - line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- **Write burst:** line_i=0xDDDD..CCCC..BBBB..AAAA (beat 0 = 0xAAAA..) with resp_i high on 4 cycles separated by 1-cycle gaps. Required:
  - burst_o = AAAA, BBBB, CCCC, DDDD;
  - burst_o held stable across the gaps;
  - write_o high for 7 cycles;
  - resp_o single pulse.
- **Priority and hazards:**
  - read_i=write_i=1 in IDLE → WR only.
  - line_i/address_i changed mid-burst → burst_o/address_o unchanged.
  - Stray resp_i in IDLE → line_o unchanged.
- **Reset mid-burst:** rst=0 after beat 2 of a read → line_o=0, read_o=0 immediately (asynchronous). A new read after release completes normally with 4 beats.
